// File: rtl/csr_serialize_ctrl_if.sv
// Handshake bundle between the issue/pipe side and the CSR serialization sequencer.
// master = issue queue / pipeline side, slave = csr_serialize_ctrl.
interface csr_serialize_ctrl_if #(
    parameter int AL_ID_W = 7
);
    logic               recoverFlag_i;
    logic               exceptionFlag_i;
    logic               csrReqValid_i;
    logic [AL_ID_W-1:0] csrReqAlId_i;
    logic [AL_ID_W-1:0] alHeadId_i;
    logic               pipeEmpty_i;
    logic               wbValid_i;
    logic [AL_ID_W-1:0] wbAlId_i;
    logic               issueStall_o;
    logic               csrGrant_o;
    logic [AL_ID_W-1:0] csrGrantAlId_o;
    logic               csrDone_o;
    logic               busy_o;
    logic [15:0]        stallCycles_o;
    logic               timeoutErr_o;

    modport master (
        output recoverFlag_i, exceptionFlag_i, csrReqValid_i, csrReqAlId_i,
               alHeadId_i, pipeEmpty_i, wbValid_i, wbAlId_i,
        input  issueStall_o, csrGrant_o, csrGrantAlId_o, csrDone_o,
               busy_o, stallCycles_o, timeoutErr_o
    );

    modport slave (
        input  recoverFlag_i, exceptionFlag_i, csrReqValid_i, csrReqAlId_i,
               alHeadId_i, pipeEmpty_i, wbValid_i, wbAlId_i,
        output issueStall_o, csrGrant_o, csrGrantAlId_o, csrDone_o,
               busy_o, stallCycles_o, timeoutErr_o
    );
endinterface

// File: rtl/csr_serialize_ctrl.sv
// Serializes CSR-class ops: wait for head-of-active-list, drain all pipes, grant one slot, await writeback.
// Optional watchdog enabled by defining CSR_SERIAL_TIMEOUT_EN.
module csr_serialize_ctrl #(
    parameter int AL_ID_W      = 7,
    parameter int DRAIN_CYCLES = 2,
    parameter int TIMEOUT_CYC  = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    csr_serialize_ctrl_if.slave  bus
);
    localparam int DRN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    if (DRAIN_CYCLES < 1 || TIMEOUT_CYC < 2) begin : gParamCheck
        $error("csr_serialize_ctrl: DRAIN_CYCLES must be >= 1 and TIMEOUT_CYC >= 2");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_HEAD = 3'd1,
        DRAIN     = 3'd2,
        GRANT     = 3'd3,
        WAIT_WB   = 3'd4
    } state_t;

    state_t             stateQ, stateNxt;
    logic [DRN_W-1:0]   drainCntQ, drainCntNxt;
    logic [AL_ID_W-1:0] capIdQ, capIdNxt;
    logic               doneQ, doneNxt;
    logic [15:0]        stallCntQ;
    logic               grant;
    logic               flush;
    logic               issueStall;

`ifdef CSR_SERIAL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]    wdCntQ, wdCntNxt;
    logic               timeoutQ, timeoutNxt;
`endif

    function automatic logic [15:0] satInc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign flush      = bus.recoverFlag_i | bus.exceptionFlag_i;
    assign issueStall = (stateQ != IDLE) | bus.csrReqValid_i;

    always_comb begin
        stateNxt    = stateQ;
        drainCntNxt = drainCntQ;
        capIdNxt    = capIdQ;
        doneNxt     = 1'b0;
        grant       = 1'b0;
        case (stateQ)
            IDLE: begin
                if (bus.csrReqValid_i && !flush) begin
                    capIdNxt = bus.csrReqAlId_i;
                    stateNxt = WAIT_HEAD;
                end
            end
            WAIT_HEAD: begin
                if (bus.alHeadId_i == capIdQ) begin
                    stateNxt    = DRAIN;
                    drainCntNxt = DRN_W'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                // Any non-empty cycle restarts the drain window from scratch.
                if (!bus.pipeEmpty_i) begin
                    drainCntNxt = DRN_W'(DRAIN_CYCLES);
                end else if (drainCntQ <= DRN_W'(1)) begin
                    drainCntNxt = '0;
                    stateNxt    = GRANT;
                end else begin
                    drainCntNxt = drainCntQ - DRN_W'(1);
                end
            end
            GRANT: begin
                grant    = 1'b1;
                stateNxt = WAIT_WB;
            end
            WAIT_WB: begin
                if (bus.wbValid_i && (bus.wbAlId_i == capIdQ)) begin
                    doneNxt  = 1'b1;
                    stateNxt = IDLE;
                end
            end
            default: stateNxt = IDLE;
        endcase

        // Flush dominates every other transition and suppresses both pulses.
        if (flush) begin
            stateNxt = IDLE;
            grant    = 1'b0;
            doneNxt  = 1'b0;
        end

`ifdef CSR_SERIAL_TIMEOUT_EN
        timeoutNxt = timeoutQ;
        wdCntNxt   = '0;
        if ((stateQ == WAIT_HEAD || stateQ == DRAIN || stateQ == WAIT_WB) && stateNxt == stateQ) begin
            if (wdCntQ == WD_W'(TIMEOUT_CYC - 1)) begin
                stateNxt   = IDLE;
                timeoutNxt = 1'b1;
            end else begin
                wdCntNxt = wdCntQ + WD_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ    <= IDLE;
            drainCntQ <= '0;
            capIdQ    <= '0;
            doneQ     <= 1'b0;
            stallCntQ <= '0;
        end else begin
            stateQ    <= stateNxt;
            drainCntQ <= drainCntNxt;
            capIdQ    <= capIdNxt;
            doneQ     <= doneNxt;
            if (issueStall) begin
                stallCntQ <= satInc16(stallCntQ);
            end
        end
    end

`ifdef CSR_SERIAL_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdCntQ   <= '0;
            timeoutQ <= 1'b0;
        end else begin
            wdCntQ   <= wdCntNxt;
            timeoutQ <= timeoutNxt;
        end
    end
    assign bus.timeoutErr_o = timeoutQ;
`else
    assign bus.timeoutErr_o = 1'b0;
`endif

    assign bus.issueStall_o   = issueStall;
    assign bus.csrGrant_o     = grant;
    assign bus.csrGrantAlId_o = grant ? capIdQ : '0;
    assign bus.csrDone_o      = doneQ;
    assign bus.busy_o         = (stateQ != IDLE);
    assign bus.stallCycles_o  = stallCntQ;
endmodule

// File: tb/tb_csr_serialize_ctrl.sv
// Directed bench for csr_serialize_ctrl; expected grant ids flow through a scoreboard queue.
// Watchdog expectations follow CSR_SERIAL_TIMEOUT_EN.
module tb_csr_serialize_ctrl;
    localparam int AL_ID_W      = 7;
    localparam int DRAIN_CYCLES = 2;
    localparam int TIMEOUT_CYC  = 1023;

    logic clk = 1'b0;
    logic reset;
    int   passCnt  = 0;
    int   totalCnt = 0;
    logic [AL_ID_W-1:0] expQ[$];

    csr_serialize_ctrl_if #(.AL_ID_W(AL_ID_W)) bus();

    csr_serialize_ctrl #(
        .AL_ID_W     (AL_ID_W),
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic clearIn();
        bus.recoverFlag_i   = 1'b0;
        bus.exceptionFlag_i = 1'b0;
        bus.csrReqValid_i   = 1'b0;
        bus.csrReqAlId_i    = '0;
        bus.alHeadId_i      = '0;
        bus.pipeEmpty_i     = 1'b0;
        bus.wbValid_i       = 1'b0;
        bus.wbAlId_i        = '0;
    endtask

    task automatic drive(input logic [AL_ID_W-1:0] id, input logic [AL_ID_W-1:0] head, input logic pe);
        bus.csrReqValid_i = 1'b1;
        bus.csrReqAlId_i  = id;
        bus.alHeadId_i    = head;
        bus.pipeEmpty_i   = pe;
    endtask

    // Returns edges from the call until csrGrant_o is seen, or -1 if the budget runs out.
    task automatic waitGrant(output int lat, input int maxCyc);
        lat = -1;
        for (int c = 1; c <= maxCyc; c++) begin
            nxt();
            bus.csrReqValid_i = 1'b0;
            if (bus.csrGrant_o === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic runToWaitWb(input logic [AL_ID_W-1:0] id);
        drive(id, id, 1'b1);
        expQ.push_back(id);
        nxt();
        bus.csrReqValid_i = 1'b0;
        repeat (4) nxt();
    endtask

    // Scoreboard consumer: every grant must match the oldest expected id.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.csrGrant_o === 1'b1) begin
            chk("sb_grant_expected", 32'(expQ.size() != 0), 1);
            if (expQ.size() != 0) chk("sb_grant_id", 32'(bus.csrGrantAlId_o), 32'(expQ.pop_front()));
        end
    end

    initial begin
        int   lat;
        logic stallAll;
        logic grantSeen;

        clearIn();
        reset = 1'b1;
        repeat (3) nxt();
        chk("rst_issueStall", 32'(bus.issueStall_o), 0);
        chk("rst_grant", 32'(bus.csrGrant_o), 0);
        chk("rst_done", 32'(bus.csrDone_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_stallCycles", 32'(bus.stallCycles_o), 0);
        chk("rst_timeout", 32'(bus.timeoutErr_o), 0);
        reset = 1'b0;
        nxt();
        chk("post_rst_busy", 32'(bus.busy_o), 0);

        // Already at head and drained: request to grant is 2 + DRAIN_CYCLES.
        drive(7'd5, 7'd5, 1'b1);
        expQ.push_back(7'd5);
        #1 chk("t1_stall_comb", 32'(bus.issueStall_o), 1);
        waitGrant(lat, 20);
        chk("t1_latency", 32'(lat), 32'(2 + DRAIN_CYCLES));
        chk("t1_grant_id", 32'(bus.csrGrantAlId_o), 5);
        nxt();
        chk("t1_grant_one_cycle", 32'(bus.csrGrant_o), 0);
        chk("t1_busy_wait_wb", 32'(bus.busy_o), 1);
        bus.wbValid_i = 1'b1;
        bus.wbAlId_i  = 7'd5;
        nxt();
        bus.wbValid_i = 1'b0;
        chk("t1_done", 32'(bus.csrDone_o), 1);
        chk("t1_idle_after_done", 32'(bus.busy_o), 0);
        nxt();
        chk("t1_done_pulse", 32'(bus.csrDone_o), 0);

        // Head lags for 10 cycles; head match is sampled in WAIT_HEAD, so the
        // grant follows 1 + DRAIN_CYCLES edges after head becomes 9.
        drive(7'd9, 7'd7, 1'b1);
        expQ.push_back(7'd9);
        nxt();
        bus.csrReqValid_i = 1'b0;
        stallAll  = 1'b1;
        grantSeen = 1'b0;
        repeat (10) begin
            nxt();
            stallAll  = stallAll & bus.issueStall_o;
            grantSeen = grantSeen | bus.csrGrant_o;
        end
        chk("t2_no_grant_before_head", 32'(grantSeen), 0);
        chk("t2_stall_while_waiting", 32'(stallAll), 1);
        bus.alHeadId_i = 7'd9;
        waitGrant(lat, 20);
        chk("t2_latency_after_head", 32'(lat), 32'(1 + DRAIN_CYCLES));
        chk("t2_stall_at_grant", 32'(bus.issueStall_o), 1);
        nxt();
        bus.wbValid_i = 1'b1;
        bus.wbAlId_i  = 7'd9;
        nxt();
        bus.wbValid_i = 1'b0;
        chk("t2_done", 32'(bus.csrDone_o), 1);

        // pipeEmpty 1,0,1,1 while draining: the 0 reloads the counter.
        drive(7'h20, 7'h20, 1'b0);
        expQ.push_back(7'h20);
        nxt();
        bus.csrReqValid_i = 1'b0;
        nxt();
        bus.pipeEmpty_i = 1'b1;
        nxt();
        chk("t3_no_grant_e1", 32'(bus.csrGrant_o), 0);
        bus.pipeEmpty_i = 1'b0;
        nxt();
        chk("t3_no_grant_e0", 32'(bus.csrGrant_o), 0);
        bus.pipeEmpty_i = 1'b1;
        nxt();
        chk("t3_no_grant_reload", 32'(bus.csrGrant_o), 0);
        nxt();
        chk("t3_grant", 32'(bus.csrGrant_o), 1);
        chk("t3_grant_id", 32'(bus.csrGrantAlId_o), 32'h20);
        nxt();
        bus.wbValid_i = 1'b1;
        bus.wbAlId_i  = 7'h20;
        nxt();
        bus.wbValid_i = 1'b0;
        chk("t3_done", 32'(bus.csrDone_o), 1);
        nxt();

        // Recover flush beats a matching writeback.
        runToWaitWb(7'h11);
        chk("t4_in_wait_wb", 32'(bus.busy_o), 1);
        bus.wbValid_i     = 1'b1;
        bus.wbAlId_i      = 7'h11;
        bus.recoverFlag_i = 1'b1;
        nxt();
        clearIn();
        chk("t4_flush_no_done", 32'(bus.csrDone_o), 0);
        chk("t4_flush_idle", 32'(bus.busy_o), 0);
        nxt();
        chk("t4_flush_no_late_done", 32'(bus.csrDone_o), 0);

        // Exception on the cycle DRAIN would move to GRANT cancels the grant.
        drive(7'h12, 7'h12, 1'b1);
        nxt();
        bus.csrReqValid_i = 1'b0;
        nxt();
        nxt();
        bus.exceptionFlag_i = 1'b1;
        nxt();
        bus.exceptionFlag_i = 1'b0;
        chk("t4_exc_no_grant", 32'(bus.csrGrant_o), 0);
        chk("t4_exc_idle", 32'(bus.busy_o), 0);
        grantSeen = 1'b0;
        repeat (5) begin
            nxt();
            grantSeen = grantSeen | bus.csrGrant_o;
        end
        chk("t4_exc_no_late_grant", 32'(grantSeen), 0);

        // Flush beats a new request in IDLE.
        drive(7'h13, 7'h13, 1'b1);
        bus.recoverFlag_i = 1'b1;
        nxt();
        clearIn();
        chk("t4_flush_blocks_capture", 32'(bus.busy_o), 0);

        // Writeback for another id is ignored.
        runToWaitWb(7'd4);
        bus.wbValid_i = 1'b1;
        bus.wbAlId_i  = 7'd3;
        nxt();
        chk("t6_wrong_wb_busy", 32'(bus.busy_o), 1);
        chk("t6_wrong_wb_no_done", 32'(bus.csrDone_o), 0);
        bus.wbAlId_i = 7'd4;
        nxt();
        bus.wbValid_i = 1'b0;
        chk("t6_right_wb_done", 32'(bus.csrDone_o), 1);
        nxt();

        // Asynchronous reset while in GRANT drops the pulse immediately.
        drive(7'h30, 7'h30, 1'b1);
        nxt();
        bus.csrReqValid_i = 1'b0;
        repeat (3) nxt();
        #1;
        chk("t6_in_grant", 32'(bus.csrGrant_o), 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_grant_drop", 32'(bus.csrGrant_o), 0);
        chk("t6_rst_idle", 32'(bus.busy_o), 0);
        chk("t6_rst_stall_clr", 32'(bus.stallCycles_o), 0);
        nxt();
        clearIn();
        reset = 1'b0;
        nxt();
        chk("t6_after_rst_no_grant", 32'(bus.csrGrant_o), 0);

        // Held request with head mismatch: stall counter saturates, watchdog optional.
        drive(7'h40, 7'h41, 1'b1);
        for (int k = 1; k <= 70000; k++) begin
            nxt();
            if (k == 1000) chk("t5_stall_1000", 32'(bus.stallCycles_o), 1000);
            if (k == TIMEOUT_CYC + 1) begin
`ifdef CSR_SERIAL_TIMEOUT_EN
                chk("t5_timeout_set", 32'(bus.timeoutErr_o), 1);
                chk("t5_timeout_idle", 32'(bus.busy_o), 0);
`else
                chk("t5_timeout_off", 32'(bus.timeoutErr_o), 0);
                chk("t5_still_busy", 32'(bus.busy_o), 1);
`endif
            end
            if (k == 65535) chk("t5_stall_sat_reach", 32'(bus.stallCycles_o), 32'hFFFF);
        end
        chk("t5_stall_sat_hold", 32'(bus.stallCycles_o), 32'hFFFF);
        clearIn();
        nxt();
        chk("sb_all_grants_seen", 32'(expQ.size()), 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
